score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//   Match controller for the two-player tug-of-war game. Counts round wins per
//   player and sequences the playfield through round restarts. Detects game over
//   at WIN_SCORE. Drives the 3-bit score buses that feed the two HEX 7-seg decoders.
//   Sits between the playfield logic (win pulses in) and the display decoders.
// PARAMETERS
//   WIN_SCORE      3'd7  score that ends the match; legal 1..7
//   RESTART_CYCLES 4     cycles round_restart is held high after a round; legal 1..255
//   BLINK_PERIOD   25    cycles per blink half-period (BLINK_EN only); legal 1..2^24-1
// PORTS
//   clk           in   1  system clock
//   reset         in   1  synchronous, active-high reset
//   l_win         in   1  1-cycle pulse: left player won the current round
//   r_win         in   1  1-cycle pulse: right player won the current round
//   clear         in   1  start a new match (level, sampled each clk)
//   l_score       out  3  left score to HEX decoder
//   r_score       out  3  right score to HEX decoder
//   round_restart out  1  high while playfield must recentre/hold
//   game_over     out  1  high in DONE
//   winner        out  1  0=left, 1=right; valid only while game_over=1
//   winner_blank  out  1  blank winner's HEX digit (blink); 0 without BLINK_EN
// BEHAVIOUR
//   - Reset is synchronous and active-high. It is sampled on the rising edge of clk.
//     * Reset has priority over every other input.
//     * Values after reset: state=PLAY, l_score=0, r_score=0, round_restart=0,
//       game_over=0, winner=0, winner_blank=0, restart counter=0.
//   - FSM states: PLAY, RESTART, DONE.
//   - PLAY:
//     * l_win^r_win at edge N: the winner's score increments. The new value is
//       visible after edge N (1-cycle latency).
//     * If the new score == WIN_SCORE: go to DONE. Set game_over=1. Latch winner.
//       round_restart stays 0.
//     * Otherwise: go to RESTART. round_restart=1 starting the cycle after edge N.
//     * l_win&r_win together: tie. No score change. Go to RESTART.
//   - RESTART:
//     * round_restart is held high for exactly RESTART_CYCLES cycles, then the FSM
//       returns to PLAY and round_restart drops.
//     * l_win/r_win are ignored.
//   - DONE:
//     * Scores are frozen. Win pulses are ignored.
//     * The FSM leaves DONE only on clear or reset.
//   - clear=1 in any state, with reset=0:
//     * Scores go to 0. game_over=0, winner=0.
//     * The FSM enters RESTART with the counter reloaded, so round_restart is held
//       for RESTART_CYCLES cycles.
//     * clear has priority over win pulses in the same cycle.
//     * clear held high keeps the counter reloaded. The RESTART count starts after
//       clear falls.
//   - Scores are 3-bit unsigned and never exceed WIN_SCORE.
//     * With WIN_SCORE=7 there is no wrap-around. Reaching 7 always forces DONE.
//   - All outputs are registered. There are no combinational input-to-output paths.
// CONFIGURATION
//   - SCORE_KEEPER_BLINK_EN defined:
//     * In DONE, a counter toggles winner_blank every BLINK_PERIOD cycles.
//     * winner_blank is 0 on the first DONE cycle.
//     * The counter is cleared on leaving DONE, and winner_blank returns to 0.
//   - SCORE_KEEPER_BLINK_EN undefined:
//     * winner_blank is tied to 0.
//     * No blink counter is instantiated.
// TESTING
//   1. reset, then one l_win pulse -> next cycle l_score=1, r_score=0. round_restart
//      is high for 4 cycles, then the FSM is back in PLAY.
//   2. l_win during RESTART -> l_score unchanged. round_restart length unchanged (4).
//   3. l_win and r_win in the same cycle -> scores unchanged. round_restart high for
//      4 cycles.
//   4. 7 r_win pulses, each in PLAY -> r_score=7, game_over=1, winner=1.
//      round_restart stays 0 after the 7th pulse. Further pulses are ignored.
//   5. In DONE, apply clear with a simultaneous l_win -> scores 0, game_over=0,
//      round_restart high for 4 cycles after clear falls.
//   6. reset asserted mid-RESTART with r_score=3 -> next cycle all outputs 0,
//      FSM=PLAY. With BLINK_EN and BLINK_PERIOD=2: in DONE, winner_blank runs
//      0,0,1,1,0,0...

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: match controller for the two-player tug-of-war game.
// Counts round wins per player, holds the playfield in round_restart between
// rounds, and flags game over once a player reaches WIN_SCORE.
// Optional feature: define SCORE_KEEPER_BLINK_EN to blink the winner's digit
// in DONE (adds the BLINK_PERIOD parameter and a blink counter).
module score_keeper #(
`ifdef SCORE_KEEPER_BLINK_EN
    parameter int         BLINK_PERIOD   = 25,
`endif
    parameter logic [2:0] WIN_SCORE      = 3'd7,
    parameter int         RESTART_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       l_win,
    input  logic       r_win,
    input  logic       clear,
    output logic [2:0] l_score,
    output logic [2:0] r_score,
    output logic       round_restart,
    output logic       game_over,
    output logic       winner,
    output logic       winner_blank
);

    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        RESTART = 2'd1,
        DONE    = 2'd2
    } state_t;

    // The counter is loaded with one less than the hold length so that
    // round_restart stays high for exactly RESTART_CYCLES cycles.
    localparam logic [7:0] RESTART_RELOAD = 8'(RESTART_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] l_score_q, l_score_d;
    logic [2:0] r_score_q, r_score_d;
    logic       round_restart_q, round_restart_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;
    logic [7:0] restart_cnt_q, restart_cnt_d;
    logic [2:0] l_inc;
    logic [2:0] r_inc;

    // Next-state and registered-output logic; clear overrides everything but reset.
    always_comb begin
        state_d         = state_q;
        l_score_d       = l_score_q;
        r_score_d       = r_score_q;
        round_restart_d = round_restart_q;
        game_over_d     = game_over_q;
        winner_d        = winner_q;
        restart_cnt_d   = restart_cnt_q;
        l_inc           = 3'(l_score_q + 3'd1);
        r_inc           = 3'(r_score_q + 3'd1);

        if (clear) begin
            state_d         = RESTART;
            l_score_d       = 3'd0;
            r_score_d       = 3'd0;
            game_over_d     = 1'b0;
            winner_d        = 1'b0;
            round_restart_d = 1'b1;
            restart_cnt_d   = RESTART_RELOAD;
        end else begin
            case (state_q)
                PLAY: begin
                    if (l_win && r_win) begin
                        state_d         = RESTART;
                        round_restart_d = 1'b1;
                        restart_cnt_d   = RESTART_RELOAD;
                    end else if (l_win) begin
                        l_score_d = l_inc;
                        if (l_inc == WIN_SCORE) begin
                            state_d     = DONE;
                            game_over_d = 1'b1;
                            winner_d    = 1'b0;
                        end else begin
                            state_d         = RESTART;
                            round_restart_d = 1'b1;
                            restart_cnt_d   = RESTART_RELOAD;
                        end
                    end else if (r_win) begin
                        r_score_d = r_inc;
                        if (r_inc == WIN_SCORE) begin
                            state_d     = DONE;
                            game_over_d = 1'b1;
                            winner_d    = 1'b1;
                        end else begin
                            state_d         = RESTART;
                            round_restart_d = 1'b1;
                            restart_cnt_d   = RESTART_RELOAD;
                        end
                    end
                end
                RESTART: begin
                    if (restart_cnt_q == 8'd0) begin
                        state_d         = PLAY;
                        round_restart_d = 1'b0;
                    end else begin
                        restart_cnt_d = restart_cnt_q - 8'd1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d         = PLAY;
                    round_restart_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= PLAY;
            l_score_q       <= 3'd0;
            r_score_q       <= 3'd0;
            round_restart_q <= 1'b0;
            game_over_q     <= 1'b0;
            winner_q        <= 1'b0;
            restart_cnt_q   <= 8'd0;
        end else begin
            state_q         <= state_d;
            l_score_q       <= l_score_d;
            r_score_q       <= r_score_d;
            round_restart_q <= round_restart_d;
            game_over_q     <= game_over_d;
            winner_q        <= winner_d;
            restart_cnt_q   <= restart_cnt_d;
        end
    end

    assign l_score       = l_score_q;
    assign r_score       = r_score_q;
    assign round_restart = round_restart_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;

`ifdef SCORE_KEEPER_BLINK_EN
    localparam logic [23:0] BLINK_LAST = 24'(BLINK_PERIOD - 1);

    logic [23:0] blink_cnt_q, blink_cnt_d;
    logic        winner_blank_q, winner_blank_d;

    // Blink timer runs only while staying in DONE; anything else clears it.
    always_comb begin
        blink_cnt_d    = 24'd0;
        winner_blank_d = 1'b0;
        if (state_q == DONE && state_d == DONE) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d    = 24'd0;
                winner_blank_d = ~winner_blank_q;
            end else begin
                blink_cnt_d    = blink_cnt_q + 24'd1;
                winner_blank_d = winner_blank_q;
            end
        end
    end

    // Blink registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q    <= 24'd0;
            winner_blank_q <= 1'b0;
        end else begin
            blink_cnt_q    <= blink_cnt_d;
            winner_blank_q <= winner_blank_d;
        end
    end

    assign winner_blank = winner_blank_q;
`else
    assign winner_blank = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed checks of score_keeper with default parameters
// (WIN_SCORE=7, RESTART_CYCLES=4, blink feature disabled).
module tb_score_keeper;

    logic       clk;
    logic       reset;
    logic       l_win;
    logic       r_win;
    logic       clear;
    logic [2:0] l_score;
    logic [2:0] r_score;
    logic       round_restart;
    logic       game_over;
    logic       winner;
    logic       winner_blank;

    int pass_count  = 0;
    int check_count = 0;

    score_keeper dut (
        .clk          (clk),
        .reset        (reset),
        .l_win        (l_win),
        .r_win        (r_win),
        .clear        (clear),
        .l_score      (l_score),
        .r_score      (r_score),
        .round_restart(round_restart),
        .game_over    (game_over),
        .winner       (winner),
        .winner_blank (winner_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait out a restart hold without checking it.
    task automatic wait_restart();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; l_win = 1'b0; r_win = 1'b0; clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_count++;
        if ({l_score, r_score, round_restart, game_over, winner, winner_blank} !== 10'd0)
            $display("[TB] FAIL reset_outputs: got %b expected %b",
                     {l_score, r_score, round_restart, game_over, winner, winner_blank}, 10'd0);
        else pass_count++;
    endtask

    task automatic test_single_win();
        l_win = 1'b1;
        tick();
        l_win = 1'b0;
        check_count++;
        if ({l_score, r_score} !== {3'd1, 3'd0})
            $display("[TB] FAIL single_win_scores: got l=%0d r=%0d expected l=1 r=0", l_score, r_score);
        else pass_count++;
        for (int i = 0; i < 4; i++) begin
            check_count++;
            if (round_restart !== 1'b1)
                $display("[TB] FAIL single_win_restart_%0d: got %b expected 1", i, round_restart);
            else pass_count++;
            tick();
        end
        check_count++;
        if (round_restart !== 1'b0)
            $display("[TB] FAIL single_win_restart_end: got %b expected 0", round_restart);
        else pass_count++;
        // Back in PLAY: a right win must be accepted now.
        r_win = 1'b1;
        tick();
        r_win = 1'b0;
        check_count++;
        if ({l_score, r_score, round_restart} !== {3'd1, 3'd1, 1'b1})
            $display("[TB] FAIL single_win_play_again: got l=%0d r=%0d rr=%b expected l=1 r=1 rr=1",
                     l_score, r_score, round_restart);
        else pass_count++;
        wait_restart();
    endtask

    task automatic test_win_during_restart();
        l_win = 1'b1;
        tick();
        // Keep l_win high for the whole hold; it must be ignored.
        for (int i = 0; i < 4; i++) begin
            check_count++;
            if ({l_score, round_restart} !== {3'd2, 1'b1})
                $display("[TB] FAIL restart_ignore_%0d: got l=%0d rr=%b expected l=2 rr=1",
                         i, l_score, round_restart);
            else pass_count++;
            tick();
        end
        l_win = 1'b0;
        check_count++;
        if ({l_score, round_restart} !== {3'd2, 1'b0})
            $display("[TB] FAIL restart_ignore_end: got l=%0d rr=%b expected l=2 rr=0", l_score, round_restart);
        else pass_count++;
    endtask

    task automatic test_tie();
        l_win = 1'b1;
        r_win = 1'b1;
        tick();
        l_win = 1'b0;
        r_win = 1'b0;
        check_count++;
        if ({l_score, r_score} !== {3'd2, 3'd1})
            $display("[TB] FAIL tie_scores: got l=%0d r=%0d expected l=2 r=1", l_score, r_score);
        else pass_count++;
        for (int i = 0; i < 4; i++) begin
            check_count++;
            if (round_restart !== 1'b1)
                $display("[TB] FAIL tie_restart_%0d: got %b expected 1", i, round_restart);
            else pass_count++;
            tick();
        end
        check_count++;
        if (round_restart !== 1'b0)
            $display("[TB] FAIL tie_restart_end: got %b expected 0", round_restart);
        else pass_count++;
    endtask

    task automatic test_game_over();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            r_win = 1'b1;
            tick();
            r_win = 1'b0;
            if (i < 7) begin
                check_count++;
                if ({r_score, round_restart, game_over} !== {3'(i), 1'b1, 1'b0})
                    $display("[TB] FAIL game_over_step_%0d: got r=%0d rr=%b go=%b expected r=%0d rr=1 go=0",
                             i, r_score, round_restart, game_over, i);
                else pass_count++;
                wait_restart();
            end
        end
        check_count++;
        if ({r_score, l_score, round_restart, game_over, winner, winner_blank} !==
            {3'd7, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0})
            $display("[TB] FAIL game_over_final: got r=%0d l=%0d rr=%b go=%b win=%b wb=%b expected r=7 l=0 rr=0 go=1 win=1 wb=0",
                     r_score, l_score, round_restart, game_over, winner, winner_blank);
        else pass_count++;
        // Further pulses are ignored in DONE.
        l_win = 1'b1;
        r_win = 1'b1;
        tick();
        r_win = 1'b0;
        tick();
        l_win = 1'b0;
        tick();
        check_count++;
        if ({r_score, l_score, round_restart, game_over, winner} !== {3'd7, 3'd0, 1'b0, 1'b1, 1'b1})
            $display("[TB] FAIL done_frozen: got r=%0d l=%0d rr=%b go=%b win=%b expected r=7 l=0 rr=0 go=1 win=1",
                     r_score, l_score, round_restart, game_over, winner);
        else pass_count++;
    endtask

    task automatic test_clear_from_done();
        clear = 1'b1;
        l_win = 1'b1;
        tick();
        l_win = 1'b0;
        check_count++;
        if ({l_score, r_score, round_restart, game_over, winner} !== {3'd0, 3'd0, 1'b1, 1'b0, 1'b0})
            $display("[TB] FAIL clear_outputs: got l=%0d r=%0d rr=%b go=%b win=%b expected l=0 r=0 rr=1 go=0 win=0",
                     l_score, r_score, round_restart, game_over, winner);
        else pass_count++;
        // Holding clear keeps the hold reloaded.
        tick();
        tick();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_count++;
            if (round_restart !== 1'b1)
                $display("[TB] FAIL clear_restart_%0d: got %b expected 1", i, round_restart);
            else pass_count++;
            tick();
        end
        check_count++;
        if ({round_restart, l_score} !== {1'b0, 3'd0})
            $display("[TB] FAIL clear_restart_end: got rr=%b l=%0d expected rr=0 l=0", round_restart, l_score);
        else pass_count++;
    endtask

    task automatic test_reset_mid_restart();
        for (int i = 0; i < 3; i++) begin
            r_win = 1'b1;
            tick();
            r_win = 1'b0;
            if (i < 2) wait_restart();
        end
        tick();
        check_count++;
        if ({r_score, round_restart} !== {3'd3, 1'b1})
            $display("[TB] FAIL mid_restart_setup: got r=%0d rr=%b expected r=3 rr=1", r_score, round_restart);
        else pass_count++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_count++;
        if ({l_score, r_score, round_restart, game_over, winner, winner_blank} !== 10'd0)
            $display("[TB] FAIL mid_restart_reset: got %b expected %b",
                     {l_score, r_score, round_restart, game_over, winner, winner_blank}, 10'd0);
        else pass_count++;
        // FSM must be in PLAY straight after reset.
        l_win = 1'b1;
        tick();
        l_win = 1'b0;
        check_count++;
        if ({l_score, r_score, round_restart} !== {3'd1, 3'd0, 1'b1})
            $display("[TB] FAIL mid_restart_play: got l=%0d r=%0d rr=%b expected l=1 r=0 rr=1",
                     l_score, r_score, round_restart);
        else pass_count++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        reset = 1'b1;
        l_win = 1'b0;
        r_win = 1'b0;
        clear = 1'b0;
        test_reset();
        test_single_win();
        test_win_during_restart();
        test_tie();
        test_game_over();
        test_clear_from_done();
        test_reset_mid_restart();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
